// File: rtl/adt7420_ctrl_if.sv
// Request/result bundle between a host and the ADT7420 I2C controller.
// The host drives the request fields; the controller returns status and data.
interface adt7420_ctrl_if;
  logic        req;
  logic        req_rd;
  logic        req_two;
  logic [7:0]  req_reg;
  logic [7:0]  req_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] rdata;

  modport master (
    output req, req_rd, req_two, req_reg, req_wdata,
    input  busy, done, err, rdata
  );

  modport slave (
    input  req, req_rd, req_two, req_reg, req_wdata,
    output busy, done, err, rdata
  );
endinterface

// File: rtl/adt7420_ctrl.sv
// I2C register read/write controller for an ADT7420 temperature sensor.
// Open-drain SCL/SDA, quarter-bit timing, abort to STOP on any target NACK.
module adt7420_ctrl #(
  parameter int         CLK_FREQ       = 100_000_000,
  parameter int         BUS_CLK        = 100_000,
  parameter logic [6:0] DEVICE_ADDRESS = 7'h4B
) (
  input  logic          clk,
  input  logic          rst,
  adt7420_ctrl_if.slave bus,
  inout  wire           scl,
  inout  wire           sda
);
  localparam int QDIV = CLK_FREQ / (4 * BUS_CLK);
  localparam int QW = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [QW-1:0] QLAST = QW'(QDIV - 1);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, REG, REG_ACK,
    WDATA, WDATA_ACK, RESTART, RADDR, RADDR_ACK,
    RDATA, MACK, STOP
  } state_t;

  state_t state, state_nx;

  logic [QW-1:0] qcnt;
  logic [1:0]    ph;
  logic [2:0]    bitcnt;
  logic          byte_n;
  logic          rd;
  logic          two;
  logic          abort;
  logic          ready;
  logic          sda_q;
  logic [7:0]    reg_q;
  logic [7:0]    wdata_q;
  logic [15:0]   rx;
  logic          done_q;
  logic          err_q;
  logic [15:0]   rdata_q;

  logic          qwrap;
  logic          bit_end;
  logic          sda_in;
  logic          accept;
  logic          scl_low;
  logic          sda_low;
  logic [7:0]    tx;
  logic          tx_bit;

  assign scl = scl_low ? 1'b0 : 1'bz;
  assign sda = sda_q ? 1'b0 : 1'bz;
  assign sda_in = sda;

  assign qwrap = (qcnt == QLAST);
  assign bit_end = qwrap && (ph == 2'd3);

  // done/err still high means busy just fell: that cycle never accepts
  assign accept = (state == IDLE) && ready && bus.req
                  && !done_q && !err_q;

  assign bus.busy  = (state != IDLE);
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

  always_comb begin
    tx = reg_q;
    unique case (1'b1)
      state == ADDR:  tx = {DEVICE_ADDRESS, 1'b0};
      state == RADDR: tx = {DEVICE_ADDRESS, 1'b1};
      state == WDATA: tx = wdata_q;
      default:        tx = reg_q;
    endcase
    tx_bit = tx[~bitcnt];
  end

  always_comb begin
    state_nx = state;
    scl_low  = 1'b0;
    sda_low  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = START;
      end
      START: begin
        scl_low = (ph == 2'd3);
        sda_low = (ph != 2'd0);
        if (bit_end) state_nx = ADDR;
      end
      ADDR: begin
        scl_low = !ph[1];
        sda_low = !tx_bit;
        if (bit_end && bitcnt == 3'd7) state_nx = ADDR_ACK;
      end
      ADDR_ACK: begin
        scl_low = !ph[1];
        if (bit_end) state_nx = sda_in ? STOP : REG;
      end
      REG: begin
        scl_low = !ph[1];
        sda_low = !tx_bit;
        if (bit_end && bitcnt == 3'd7) state_nx = REG_ACK;
      end
      REG_ACK: begin
        scl_low = !ph[1];
        if (bit_end) begin
          if (sda_in)  state_nx = STOP;
          else if (rd) state_nx = RESTART;
          else         state_nx = WDATA;
        end
      end
      WDATA: begin
        scl_low = !ph[1];
        sda_low = !tx_bit;
        if (bit_end && bitcnt == 3'd7) state_nx = WDATA_ACK;
      end
      WDATA_ACK: begin
        scl_low = !ph[1];
        if (bit_end) state_nx = STOP;
      end
      RESTART: begin
        scl_low = (ph == 2'd0) || (ph == 2'd3);
        sda_low = ph[1];
        if (bit_end) state_nx = RADDR;
      end
      RADDR: begin
        scl_low = !ph[1];
        sda_low = !tx_bit;
        if (bit_end && bitcnt == 3'd7) state_nx = RADDR_ACK;
      end
      RADDR_ACK: begin
        scl_low = !ph[1];
        if (bit_end) state_nx = sda_in ? STOP : RDATA;
      end
      RDATA: begin
        scl_low = !ph[1];
        if (bit_end && bitcnt == 3'd7) state_nx = MACK;
      end
      MACK: begin
        scl_low = !ph[1];
        sda_low = two && !byte_n;
        if (bit_end) state_nx = (two && !byte_n) ? RDATA : STOP;
      end
      STOP: begin
        scl_low = !ph[1];
        sda_low = (ph != 2'd3);
        if (bit_end) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // SDA is registered so it always moves one clock after SCL falls
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      qcnt    <= '0;
      ph      <= 2'd0;
      bitcnt  <= 3'd0;
      byte_n  <= 1'b0;
      rd      <= 1'b0;
      two     <= 1'b0;
      abort   <= 1'b0;
      ready   <= 1'b0;
      sda_q   <= 1'b0;
      reg_q   <= 8'h00;
      wdata_q <= 8'h00;
      rx      <= 16'h0000;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 16'h0000;
    end else begin
      state  <= state_nx;
      sda_q  <= sda_low;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state != IDLE || !ready) begin
        qcnt <= qwrap ? '0 : qcnt + 1'b1;
        if (qwrap) ph <= ph + 2'd1;
        if (bit_end && state == IDLE) ready <= 1'b1;
      end
      if (accept) begin
        rd      <= bus.req_rd;
        two     <= bus.req_two;
        reg_q   <= bus.req_reg;
        wdata_q <= bus.req_wdata;
        abort   <= 1'b0;
        byte_n  <= 1'b0;
        bitcnt  <= 3'd0;
      end
      if (bit_end) begin
        if (state inside {ADDR, REG, WDATA, RADDR, RDATA})
          bitcnt <= bitcnt + 3'd1;
        if (state inside {ADDR_ACK, REG_ACK, WDATA_ACK, RADDR_ACK}
            && sda_in)
          abort <= 1'b1;
        if (state == RDATA) rx <= {rx[14:0], sda_in};
        if (state == MACK) byte_n <= 1'b1;
        if (state == STOP) begin
          if (abort) begin
            err_q <= 1'b1;
          end else begin
            done_q <= 1'b1;
            if (rd) rdata_q <= two ? rx : {8'h00, rx[7:0]};
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_adt7420_ctrl.sv
// Bench: two controllers (0x4B and 0x48) share one bus with an ADT7420 model.
// Quarter-bit is 5 clocks so a bit is 20 clocks.
module tb_adt7420_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  wire  scl;
  wire  sda;

  pullup (scl);
  pullup (sda);

  always #5 clk = ~clk;

  adt7420_ctrl_if bus_a ();
  adt7420_ctrl_if bus_b ();

  adt7420_ctrl #(
    .CLK_FREQ(2_000_000), .BUS_CLK(100_000),
    .DEVICE_ADDRESS(7'h4B)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus_a), .scl(scl), .sda(sda)
  );

  adt7420_ctrl #(
    .CLK_FREQ(2_000_000), .BUS_CLK(100_000),
    .DEVICE_ADDRESS(7'h48)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .scl(scl), .sda(sda)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- ADT7420 target model ----------------
  typedef enum logic [2:0] {M_IDLE, M_RX, M_ACK, M_TX, M_MACK} mst_t;
  mst_t       ms;
  logic       m_rst = 1'b1;
  logic       m_sda_low;
  logic       ps, pd;
  logic [3:0] mb;
  logic [7:0] msh, mtx, mptr, m_cfg;
  logic       mrw, m_isaddr, mfirst, mack;
  int         starts = 0;
  int         stops = 0;

  assign sda = m_sda_low ? 1'b0 : 1'bz;

  function automatic logic [7:0] mread(input logic [7:0] p);
    case (p)
      8'h00:   return 8'h0C;
      8'h01:   return 8'h80;
      8'h03:   return m_cfg;
      8'h0B:   return 8'hCB;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    ps <= scl;
    pd <= sda;
    if (m_rst) begin
      ms <= M_IDLE; m_sda_low <= 1'b0; m_cfg <= 8'h00;
      mptr <= 8'h00; mb <= 4'd0; mrw <= 1'b0;
    end else if (ps === 1'b1 && scl === 1'b1 &&
                 pd === 1'b1 && sda === 1'b0) begin
      ms <= M_RX; m_isaddr <= 1'b1; mb <= 4'd0;
      m_sda_low <= 1'b0; starts <= starts + 1;
    end else if (ps === 1'b1 && scl === 1'b1 &&
                 pd === 1'b0 && sda === 1'b1) begin
      ms <= M_IDLE; m_sda_low <= 1'b0; stops <= stops + 1;
    end else if (ps === 1'b0 && scl === 1'b1) begin
      if (ms == M_RX) begin
        msh <= {msh[6:0], sda}; mb <= mb + 4'd1;
      end
      if (ms == M_MACK) mack <= sda;
    end else if (ps === 1'b1 && scl === 1'b0) begin
      case (ms)
        M_RX: if (mb == 4'd8) begin
          mb <= 4'd0;
          if (m_isaddr) begin
            if (msh[7:1] == 7'h4B) begin
              m_sda_low <= 1'b1; mrw <= msh[0];
              ms <= M_ACK; m_isaddr <= 1'b0; mfirst <= 1'b1;
            end else begin
              ms <= M_IDLE;
            end
          end else begin
            if (mfirst) mptr <= msh;
            else begin
              if (mptr == 8'h03) m_cfg <= msh;
              mptr <= mptr + 8'd1;
            end
            mfirst <= 1'b0; m_sda_low <= 1'b1; ms <= M_ACK;
          end
        end
        M_ACK: begin
          if (mrw) begin
            m_sda_low <= !mread(mptr)[7];
            mtx <= {mread(mptr)[6:0], 1'b0};
            mptr <= mptr + 8'd1; mb <= 4'd1; ms <= M_TX;
          end else begin
            m_sda_low <= 1'b0; mb <= 4'd0; ms <= M_RX;
          end
        end
        M_TX: begin
          if (mb == 4'd8) begin
            m_sda_low <= 1'b0; ms <= M_MACK;
          end else begin
            m_sda_low <= !mtx[7]; mtx <= {mtx[6:0], 1'b0};
            mb <= mb + 4'd1;
          end
        end
        M_MACK: begin
          if (mack == 1'b0) begin
            m_sda_low <= !mread(mptr)[7];
            mtx <= {mread(mptr)[6:0], 1'b0};
            mptr <= mptr + 8'd1; mb <= 4'd1; ms <= M_TX;
          end else begin
            m_sda_low <= 1'b0; ms <= M_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- SCL period monitor ----------------
  int   cyc = 0;
  int   rise_last = 0;
  int   rise_per = 0;
  logic sclp = 1'b1;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    sclp <= scl;
    if (sclp === 1'b0 && scl === 1'b1) begin
      rise_per <= cyc - rise_last;
      rise_last <= cyc;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input bit sel, input bit rd, input bit two,
                       input logic [7:0] r, input logic [7:0] w);
    @(negedge clk);
    if (sel) begin
      bus_b.req = 1'b1; bus_b.req_rd = rd; bus_b.req_two = two;
      bus_b.req_reg = r; bus_b.req_wdata = w;
    end else begin
      bus_a.req = 1'b1; bus_a.req_rd = rd; bus_a.req_two = two;
      bus_a.req_reg = r; bus_a.req_wdata = w;
    end
    @(negedge clk);
    bus_a.req = 1'b0;
    bus_b.req = 1'b0;
  endtask

  task automatic do_req(input bit sel, input bit rd, input bit two,
                        input logic [7:0] r, input logic [7:0] w);
    for (int i = 0; i < 4000; i++) begin
      if (!(sel ? bus_b.busy : bus_a.busy)) break;
      @(negedge clk);
    end
    pulse(sel, rd, two, r, w);
  endtask

  task automatic wait_end(input bit sel, output bit d, output bit e,
                          output bit b);
    d = 1'b0; e = 1'b0; b = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (sel ? (bus_b.done || bus_b.err) : (bus_a.done || bus_a.err)) begin
        d = sel ? bus_b.done : bus_a.done;
        e = sel ? bus_b.err : bus_a.err;
        b = sel ? bus_b.busy : bus_a.busy;
        break;
      end
    end
  endtask

  function automatic int pulses_seen();
    return int'(bus_a.done) + int'(bus_a.err);
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    bit d, e, b;
    int s0, t0, np;

    bus_a.req = 1'b0; bus_a.req_rd = 1'b0; bus_a.req_two = 1'b0;
    bus_a.req_reg = 8'h00; bus_a.req_wdata = 8'h00;
    bus_b.req = 1'b0; bus_b.req_rd = 1'b0; bus_b.req_two = 1'b0;
    bus_b.req_reg = 8'h00; bus_b.req_wdata = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus_a.busy), 32'd0);
    check("rst_done", 32'(bus_a.done), 32'd0);
    check("rst_err", 32'(bus_a.err), 32'd0);
    check("rst_rdata", 32'(bus_a.rdata), 32'h0000);
    check("rst_scl", 32'(scl), 32'd1);
    check("rst_sda", 32'(sda), 32'd1);

    rst = 1'b0;
    m_rst = 1'b0;
    pulse(1'b0, 1'b1, 1'b0, 8'h0B, 8'h00);
    repeat (3) @(negedge clk);
    check("hold_ignores_req", 32'(bus_a.busy), 32'd0);
    repeat (30) @(negedge clk);

    // two-byte temperature read
    s0 = starts; t0 = stops;
    do_req(1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    check("temp_busy", 32'(bus_a.busy), 32'd1);
    wait_end(1'b0, d, e, b);
    check("temp_done", 32'(d), 32'd1);
    check("temp_err", 32'(e), 32'd0);
    check("temp_busy_fall", 32'(b), 32'd0);
    check("temp_rdata", 32'(bus_a.rdata), 32'h0C80);
    check("scl_period", 32'(rise_per), 32'd20);
    check("temp_starts", 32'(starts - s0), 32'd2);
    check("temp_stops", 32'(stops - t0), 32'd1);

    // write config then read it back
    do_req(1'b0, 1'b0, 1'b0, 8'h03, 8'h80);
    wait_end(1'b0, d, e, b);
    check("wr_done", 32'(d), 32'd1);
    check("wr_err", 32'(e), 32'd0);
    check("wr_model_cfg", 32'(m_cfg), 32'h80);
    check("wr_rdata_kept", 32'(bus_a.rdata), 32'h0C80);

    do_req(1'b0, 1'b1, 1'b0, 8'h03, 8'h00);
    wait_end(1'b0, d, e, b);
    check("rd03_done", 32'(d), 32'd1);
    check("rd03_rdata", 32'(bus_a.rdata), 32'h0080);

    // ID read; a req in the cycle busy falls must be ignored
    do_req(1'b0, 1'b1, 1'b0, 8'h0B, 8'h00);
    wait_end(1'b0, d, e, b);
    check("id_done", 32'(d), 32'd1);
    check("id_rdata", 32'(bus_a.rdata), 32'h00CB);
    bus_a.req = 1'b1; bus_a.req_rd = 1'b0;
    @(negedge clk);
    bus_a.req = 1'b0;
    repeat (2) @(negedge clk);
    check("req_at_fall_ignored", 32'(bus_a.busy), 32'd0);

    // wrong address on second controller
    t0 = stops;
    do_req(1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
    wait_end(1'b1, d, e, b);
    check("nack_err", 32'(e), 32'd1);
    check("nack_done", 32'(d), 32'd0);
    check("nack_rdata_b", 32'(bus_b.rdata), 32'h0000);
    check("nack_stop", 32'(stops - t0), 32'd1);
    check("nack_rdata_a", 32'(bus_a.rdata), 32'h00CB);

    // second req mid-transfer is ignored
    t0 = stops; np = 0;
    do_req(1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    repeat (100) @(negedge clk);
    pulse(1'b0, 1'b0, 1'b0, 8'h03, 8'h11);
    wait_end(1'b0, d, e, b);
    check("mid_done", 32'(d), 32'd1);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      np += pulses_seen();
    end
    check("mid_no_extra", 32'(np), 32'd0);
    check("mid_rdata", 32'(bus_a.rdata), 32'h0C80);
    check("mid_stops", 32'(stops - t0), 32'd1);
    check("mid_cfg_kept", 32'(m_cfg), 32'h80);

    // reset during RDATA
    do_req(1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    repeat (640) @(negedge clk);
    rst = 1'b1; m_rst = 1'b1;
    @(negedge clk);
    check("mrst_scl", 32'(scl), 32'd1);
    check("mrst_sda", 32'(sda), 32'd1);
    check("mrst_busy", 32'(bus_a.busy), 32'd0);
    check("mrst_rdata", 32'(bus_a.rdata), 32'h0000);
    rst = 1'b0; m_rst = 1'b0;
    np = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      np += pulses_seen();
    end
    check("mrst_no_pulse", 32'(np), 32'd0);
    do_req(1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    wait_end(1'b0, d, e, b);
    check("post_rst_done", 32'(d), 32'd1);
    check("post_rst_rdata", 32'(bus_a.rdata), 32'h0C80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
